// File: rtl/move_sequencer.sv
// move_sequencer
//   Expands one-byte move instructions into enable strobes for an 8-entry
//   bank of 8-bit bus registers. The bank's enable lines are driven only
//   from here.
//   Instruction: [7:6] mode (00 MOV, 01 IMM, 10 CLR, 11 illegal),
//                [5:3] src, [2:0] dst.
//   Optional feature macro: MOVE_SEQ_IMM_EN builds the IMM_WAIT state.
//   Without it, mode 01 is rejected as illegal.
// Ports:
//   clk, res_n          clock, async active-low reset
//   instr/_valid/_ready instruction byte handshake (also carries the IMM data byte)
//   bus_in              shared register bus, sampled during READ
//   load_en, save_en    one-hot per-register load/save enables
//   save_byte           data presented to the destination register
//   busy, done, err     status: not idle / WRITE cycle / illegal accepted
module move_sequencer #(
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic [7:0]      instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [7:0]      bus_in,
  output logic [NREG-1:0] load_en,
  output logic [NREG-1:0] save_en,
  output logic [7:0]      save_byte,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_READ     = 2'd1,
    S_WRITE    = 2'd2
`ifdef MOVE_SEQ_IMM_EN
    , S_IMM_WAIT = 2'd3
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] src_q, src_d;
  logic [2:0] dst_q, dst_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;
  logic       accept;

  assign accept = instr_valid & instr_ready;

  // State register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (instr[7:6])
            2'b00: begin
              src_d   = instr[5:3];
              dst_d   = instr[2:0];
              state_d = S_READ;
            end
            2'b10: begin
              dst_d   = instr[2:0];
              data_d  = 8'h00;
              state_d = S_WRITE;
            end
`ifdef MOVE_SEQ_IMM_EN
            2'b01: begin
              dst_d   = instr[2:0];
              state_d = S_IMM_WAIT;
            end
`endif
            // Illegal opcodes leave src/dst/data untouched.
            default: err_d = 1'b1;
          endcase
        end
      end
      S_READ: begin
        data_d  = bus_in;
        state_d = S_WRITE;
      end
`ifdef MOVE_SEQ_IMM_EN
      S_IMM_WAIT: begin
        if (instr_valid) begin
          data_d  = instr;
          state_d = S_WRITE;
        end
      end
`endif
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only from registered state, so reset clears the
  // enables asynchronously and nothing follows combinationally from inputs.
  always_comb begin
    load_en     = '0;
    save_en     = '0;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE:     instr_ready = 1'b1;
      S_READ:     load_en[src_q] = 1'b1;
`ifdef MOVE_SEQ_IMM_EN
      S_IMM_WAIT: instr_ready = 1'b1;
`endif
      S_WRITE: begin
        save_en[dst_q] = 1'b1;
        done           = 1'b1;
      end
      default: ;
    endcase
  end

  // data_q only changes on the edge into WRITE, so it holds outside WRITE.
  assign save_byte = data_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;

  logic       clk;
  logic       res_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] bus_in;
  logic [7:0] load_en;
  logic [7:0] save_en;
  logic [7:0] save_byte;
  logic       busy;
  logic       done;
  logic       err;

  move_sequencer #(.NREG(8)) dut (
    .clk(clk), .res_n(res_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .bus_in(bus_in), .load_en(load_en),
    .save_en(save_en), .save_byte(save_byte), .busy(busy), .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = one cycle: inputs applied, outputs expected in that cycle.
  typedef struct {
    logic       v;
    logic [7:0] ins;
    logic [7:0] bus;
    logic       rdy;
    logic       bsy;
    logic [7:0] ld;
    logic [7:0] sv;
    logic [7:0] sb;
    logic       dn;
    logic       er;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input logic v, input logic [7:0] ins, input logic [7:0] bus,
                     input logic rdy, input logic bsy, input logic [7:0] ld,
                     input logic [7:0] sv, input logic [7:0] sb, input logic dn,
                     input logic er);
    vec_t r;
    r.v = v; r.ins = ins; r.bus = bus; r.rdy = rdy; r.bsy = bsy;
    r.ld = ld; r.sv = sv; r.sb = sb; r.dn = dn; r.er = er;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_outs(input string name, input vec_t r);
    checks++;
    if (instr_ready === r.rdy && busy === r.bsy && load_en === r.ld &&
        save_en === r.sv && save_byte === r.sb && done === r.dn && err === r.er)
      passed++;
    else
      $display("FAIL %s: got rdy=%b busy=%b ld=%h sv=%h sb=%h done=%b err=%b expected rdy=%b busy=%b ld=%h sv=%h sb=%h done=%b err=%b",
               name, instr_ready, busy, load_en, save_en, save_byte, done, err,
               r.rdy, r.bsy, r.ld, r.sv, r.sb, r.dn, r.er);
  endtask

  initial begin
    res_n = 1'b0; instr = 8'h00; instr_valid = 1'b0; bus_in = 8'h00;
    #2;
    chk("reset_outs", {load_en, save_en, save_byte, busy, done, err}, 32'h0);
    @(negedge clk); @(negedge clk);
    res_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'h0, instr_ready}, 32'h1);

    //   v  ins    bus    rdy bsy ld     sv     sb     dn er
    // MOV 0x0A: src1 -> dst2, bus 0x5C during READ
    add(1, 8'h0A, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 8'h5C, 0, 1, 8'h02, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h04, 8'h5C, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h5C, 0, 0);
    // CLR 0x83: dst3 <- 0
    add(1, 8'h83, 8'h00, 1, 0, 8'h00, 8'h00, 8'h5C, 0, 0);
    add(0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h08, 8'h00, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    // Illegal 0xC0
    add(1, 8'hC0, 8'hFF, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    // IMM 0x47 (dst7), 3-cycle valid gap, then 0xA5
    add(1, 8'h47, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
`ifdef MOVE_SEQ_IMM_EN
    add(0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1, 8'hA5, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h80, 8'hA5, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'hA5, 0, 0);
`else
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
`endif
    // Back-to-back with valid held: 0x09 (src1=dst1), then 0x12 (src2->dst2)
    add(1, 8'h09, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1, 8'h12, 8'h33, 0, 1, 8'h02, 8'h00, 8'h00, 0, 0);
    add(1, 8'h12, 8'h00, 0, 1, 8'h00, 8'h02, 8'h33, 1, 0);
    add(1, 8'h12, 8'h00, 1, 0, 8'h00, 8'h00, 8'h33, 0, 0);
    add(0, 8'h00, 8'h77, 0, 1, 8'h04, 8'h00, 8'h33, 0, 0);
    add(0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h04, 8'h77, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h77, 0, 0);
    // MOV src7 -> dst0 (index boundaries)
    add(1, 8'h38, 8'h00, 1, 0, 8'h00, 8'h00, 8'h77, 0, 0);
    add(0, 8'h00, 8'hE1, 0, 1, 8'h80, 8'h00, 8'h77, 0, 0);
    add(0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h01, 8'hE1, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'hE1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      instr_valid = vecs[i].v; instr = vecs[i].ins; bus_in = vecs[i].bus;
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i]);
      if ((load_en != 0 && save_en != 0) || $countones(load_en) > 1 ||
          $countones(save_en) > 1) begin
        checks++;
        $display("FAIL onehot_vec%0d: got ld=%h sv=%h expected disjoint one-hot", i, load_en, save_en);
      end
    end

    // Reset during READ drops load_en at once; no write after release.
    @(negedge clk);
    instr_valid = 1'b1; instr = 8'h0A; bus_in = 8'h11;
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("pre_reset_read_ld", {24'h0, load_en}, 32'h02);
    #2;
    res_n = 1'b0;
    #1;
    chk("mid_read_reset_ld", {24'h0, load_en}, 32'h0);
    chk("mid_read_reset_st", {29'h0, busy, done, err}, 32'h0);
    @(negedge clk);
    res_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("post_reset_c%0d", i), {22'h0, instr_ready, busy, save_en}, 32'h200);
      @(negedge clk);
    end

    // Reset during WRITE (CLR) drops save_en at once.
    instr_valid = 1'b1; instr = 8'h85;
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("pre_reset_write_sv", {23'h0, done, save_en}, 32'h120);
    #2;
    res_n = 1'b0;
    #1;
    chk("mid_write_reset", {23'h0, done, save_en}, 32'h0);
    @(negedge clk);
    res_n = 1'b1;
    #1;
    chk("post_write_reset", {22'h0, instr_ready, busy, save_en}, 32'h200);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish before 50000");
    $fatal(1);
  end

endmodule
